// File: rtl/ascon_fsm.sv
// Control FSM for an Ascon-128 style encryption datapath: sequences the
// initialisation, AD, PT and finalisation permutations and drives the datapath enables.
module ascon_fsm (
  input  logic       clk_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  input  logic       data_last_i,
  output logic       data_ready_o,
  output logic       select_o,
  output logic [3:0] round_o,
  output logic       en_reg_state_o,
  output logic       en_xor_data_o,
  output logic       en_xor_begin_key_o,
  output logic       en_xor_lsb_o,
  output logic       en_xor_end_key_o,
  output logic       en_out_cipher_o,
  output logic       en_out_tag_o,
  output logic       cipher_valid_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_WAIT_AD, S_AD_RND, S_WAIT_PT, S_PT_RND, S_FINAL, S_TAG, S_END
  } state_e;

  localparam logic [3:0] LAST_RND  = 4'd11;
  localparam logic [3:0] PB_FIRST  = 4'd6;

  state_e     state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic       last_ad_q, last_ad_d;
  logic       cipher_valid_q, cipher_valid_d;
  logic       done_q, done_d;
  logic       xfer;

  // Ready depends on state only, so the Mealy transfer term has no combinational loop.
  assign data_ready_o   = (state_q == S_WAIT_AD) || (state_q == S_WAIT_PT);
  assign xfer           = data_valid_i & data_ready_o;
  assign busy_o         = (state_q != S_IDLE);
  assign cipher_valid_o = cipher_valid_q;
  assign done_o         = done_q;

  always_comb begin
    // NOTE: every output and next-state signal gets a default first so no path infers a latch.
    state_d            = state_q;
    rnd_d              = rnd_q;
    last_ad_d          = last_ad_q;
    select_o           = 1'b1;
    round_o            = '0;
    en_reg_state_o     = 1'b0;
    en_xor_data_o      = 1'b0;
    en_xor_begin_key_o = 1'b0;
    en_xor_lsb_o       = 1'b0;
    en_xor_end_key_o   = 1'b0;
    en_out_cipher_o    = 1'b0;
    en_out_tag_o       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_INIT;
          rnd_d   = '0;
        end
      end
      S_INIT: begin
        en_reg_state_o = 1'b1;
        round_o        = rnd_q;
        select_o       = (rnd_q != 4'd0);
        if (rnd_q == LAST_RND) begin
          en_xor_end_key_o = 1'b1;
          rnd_d            = '0;
          state_d          = S_WAIT_AD;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      S_WAIT_AD: begin
        if (xfer) begin
          round_o        = PB_FIRST;
          en_xor_data_o  = 1'b1;
          en_reg_state_o = 1'b1;
          rnd_d          = PB_FIRST + 4'd1;
          last_ad_d      = data_last_i;
          state_d        = S_AD_RND;
        end
      end
      S_AD_RND: begin
        en_reg_state_o = 1'b1;
        round_o        = rnd_q;
        if (rnd_q == LAST_RND) begin
          en_xor_lsb_o = last_ad_q;
          rnd_d        = '0;
          state_d      = last_ad_q ? S_WAIT_PT : S_WAIT_AD;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      S_WAIT_PT: begin
        if (xfer) begin
          en_xor_data_o   = 1'b1;
          en_out_cipher_o = 1'b1;
          en_reg_state_o  = 1'b1;
          if (data_last_i) begin
            // Last PT block starts the full-length finalisation permutation.
            round_o            = '0;
            en_xor_begin_key_o = 1'b1;
            rnd_d              = 4'd1;
            state_d            = S_FINAL;
          end else begin
            round_o = PB_FIRST;
            rnd_d   = PB_FIRST + 4'd1;
            state_d = S_PT_RND;
          end
        end
      end
      S_PT_RND: begin
        en_reg_state_o = 1'b1;
        round_o        = rnd_q;
        if (rnd_q == LAST_RND) begin
          rnd_d   = '0;
          state_d = S_WAIT_PT;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      S_FINAL: begin
        en_reg_state_o = 1'b1;
        round_o        = rnd_q;
        if (rnd_q == LAST_RND) begin
          en_xor_end_key_o = 1'b1;
          rnd_d            = '0;
          state_d          = S_TAG;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      S_TAG:   begin
        en_out_tag_o = 1'b1;
        state_d      = S_END;
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cipher_valid_d = en_out_cipher_o;
    done_d         = (state_q == S_TAG);
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q        <= S_IDLE;
      rnd_q          <= '0;
      last_ad_q      <= 1'b0;
      cipher_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rnd_q          <= rnd_d;
      last_ad_q      <= last_ad_d;
      cipher_valid_q <= cipher_valid_d;
      done_q         <= done_d;
    end
  end

  a_round_range: assert property (@(posedge clk_i) disable iff (!resetb_i)
    round_o <= LAST_RND);
  a_pb_rounds: assert property (@(posedge clk_i) disable iff (!resetb_i)
    (state_q == S_AD_RND || state_q == S_PT_RND) |-> round_o >= PB_FIRST);
  a_key_excl: assert property (@(posedge clk_i) disable iff (!resetb_i)
    !(en_xor_lsb_o && en_xor_end_key_o));

endmodule

// File: tb/tb_ascon_fsm.sv
// Scoreboard bench for ascon_fsm: expected per-cycle output vectors are queued
// per message and compared by an independent monitor on every busy cycle.
module tb_ascon_fsm;

  logic       clk_i = 1'b0;
  logic       resetb_i;
  logic       start_i;
  logic       data_valid_i;
  logic       data_last_i;
  logic       data_ready_o;
  logic       select_o;
  logic [3:0] round_o;
  logic       en_reg_state_o;
  logic       en_xor_data_o;
  logic       en_xor_begin_key_o;
  logic       en_xor_lsb_o;
  logic       en_xor_end_key_o;
  logic       en_out_cipher_o;
  logic       en_out_tag_o;
  logic       cipher_valid_o;
  logic       busy_o;
  logic       done_o;

  typedef struct packed {
    logic       ready;
    logic       sel;
    logic [3:0] round;
    logic       reg_st;
    logic       xdata;
    logic       xbegin;
    logic       xlsb;
    logic       xend;
    logic       ocipher;
    logic       otag;
    logic       cv;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t exp_q[$];
  int   n_cmp     = 0;
  int   n_err     = 0;
  int   n_trace   = 0;
  int   done_cnt  = 0;
  int   n_start   = 0;
  int   n_abort   = 0;

  ascon_fsm dut (
    .clk_i              (clk_i),
    .resetb_i           (resetb_i),
    .start_i            (start_i),
    .data_valid_i       (data_valid_i),
    .data_last_i        (data_last_i),
    .data_ready_o       (data_ready_o),
    .select_o           (select_o),
    .round_o            (round_o),
    .en_reg_state_o     (en_reg_state_o),
    .en_xor_data_o      (en_xor_data_o),
    .en_xor_begin_key_o (en_xor_begin_key_o),
    .en_xor_lsb_o       (en_xor_lsb_o),
    .en_xor_end_key_o   (en_xor_end_key_o),
    .en_out_cipher_o    (en_out_cipher_o),
    .en_out_tag_o       (en_out_tag_o),
    .cipher_valid_o     (cipher_valid_o),
    .busy_o             (busy_o),
    .done_o             (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t sample();
    vec_t v;
    v.ready   = data_ready_o;
    v.sel     = select_o;
    v.round   = round_o;
    v.reg_st  = en_reg_state_o;
    v.xdata   = en_xor_data_o;
    v.xbegin  = en_xor_begin_key_o;
    v.xlsb    = en_xor_lsb_o;
    v.xend    = en_xor_end_key_o;
    v.ocipher = en_out_cipher_o;
    v.otag    = en_out_tag_o;
    v.cv      = cipher_valid_o;
    v.busy    = busy_o;
    v.done    = done_o;
    return v;
  endfunction

  function automatic vec_t busy_v();
    vec_t v;
    v      = '0;
    v.sel  = 1'b1;
    v.busy = 1'b1;
    return v;
  endfunction

  // Hand-written schedule: 12 init rounds, per block (waits, transfer, rounds 7..11),
  // last PT block enters the 12-round finalisation, then TAG and END.
  task automatic push_msg(input int n_ad, input int n_pt, input int dly);
    vec_t v;
    for (int r = 0; r < 12; r++) begin
      v = busy_v(); v.sel = (r != 0); v.round = 4'(r); v.reg_st = 1'b1; v.xend = (r == 11);
      exp_q.push_back(v);
    end
    for (int a = 0; a < n_ad; a++) begin
      for (int d = 0; d < dly; d++) begin
        v = busy_v(); v.ready = 1'b1; exp_q.push_back(v);
      end
      v = busy_v(); v.ready = 1'b1; v.round = 4'd6; v.xdata = 1'b1; v.reg_st = 1'b1;
      exp_q.push_back(v);
      for (int r = 7; r < 12; r++) begin
        v = busy_v(); v.round = 4'(r); v.reg_st = 1'b1; v.xlsb = (r == 11) && (a == n_ad - 1);
        exp_q.push_back(v);
      end
    end
    for (int p = 0; p < n_pt - 1; p++) begin
      for (int d = 0; d < dly; d++) begin
        v = busy_v(); v.ready = 1'b1; exp_q.push_back(v);
      end
      v = busy_v(); v.ready = 1'b1; v.round = 4'd6; v.xdata = 1'b1; v.ocipher = 1'b1;
      v.reg_st = 1'b1;
      exp_q.push_back(v);
      for (int r = 7; r < 12; r++) begin
        v = busy_v(); v.round = 4'(r); v.reg_st = 1'b1; v.cv = (r == 7);
        exp_q.push_back(v);
      end
    end
    for (int d = 0; d < dly; d++) begin
      v = busy_v(); v.ready = 1'b1; exp_q.push_back(v);
    end
    v = busy_v(); v.ready = 1'b1; v.round = 4'd0; v.xdata = 1'b1; v.xbegin = 1'b1;
    v.ocipher = 1'b1; v.reg_st = 1'b1;
    exp_q.push_back(v);
    for (int r = 1; r < 12; r++) begin
      v = busy_v(); v.round = 4'(r); v.reg_st = 1'b1; v.cv = (r == 1); v.xend = (r == 11);
      exp_q.push_back(v);
    end
    v = busy_v(); v.otag = 1'b1; exp_q.push_back(v);
    v = busy_v(); v.done = 1'b1; exp_q.push_back(v);
  endtask

  task automatic start_msg(input logic keep);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = keep;
    n_start++;
  endtask

  task automatic send_block(input logic last, input int dly, input logic hold);
    int budget = 0;
    while (!data_ready_o && budget < 200) begin
      @(posedge clk_i); #1;
      budget++;
    end
    if (!data_ready_o) check("ready_timeout", 32'(data_ready_o), 32'd1);
    repeat (dly) begin
      @(posedge clk_i); #1;
    end
    data_valid_i = 1'b1;
    data_last_i  = last;
    @(posedge clk_i); #1;
    if (!hold) begin
      data_valid_i = 1'b0;
      data_last_i  = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int budget = 0;
    while (busy_o && budget < 300) begin
      @(posedge clk_i); #1;
      budget++;
    end
    check("idle_timeout", 32'(busy_o), 32'd0);
  endtask

  // Monitor: every busy cycle (plus any stray pulse) must match the next queued vector.
  initial begin
    vec_t o, e;
    forever begin
      @(negedge clk_i);
      if (resetb_i && (busy_o || cipher_valid_o || done_o)) begin
        o = sample();
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(o), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("trace[%0d]", n_trace), 32'(o), 32'(e));
        end
        n_trace++;
        if (done_o) done_cnt++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rst_v;
    rst_v     = '0;
    rst_v.sel = 1'b1;

    resetb_i     = 1'b0;
    start_i      = 1'b0;
    data_valid_i = 1'b0;
    data_last_i  = 1'b0;
    #1;
    check("reset_outputs", 32'(sample()), 32'(rst_v));
    repeat (2) @(posedge clk_i);
    #3 resetb_i = 1'b1;
    @(posedge clk_i); #1;

    // 1 AD + 1 PT, valid/last held high throughout (also exercises valid outside waits)
    data_valid_i = 1'b1; data_last_i = 1'b1;
    push_msg(1, 1, 0);
    start_msg(1'b0);
    send_block(1'b1, 0, 1'b1);
    send_block(1'b1, 0, 1'b1);
    wait_idle();
    data_valid_i = 1'b0; data_last_i = 1'b0;

    // 3 AD + 2 PT, each block delayed 3 ready cycles
    push_msg(3, 2, 3);
    start_msg(1'b0);
    send_block(1'b0, 3, 1'b0);
    send_block(1'b0, 3, 1'b0);
    send_block(1'b1, 3, 1'b0);
    send_block(1'b0, 3, 1'b0);
    send_block(1'b1, 3, 1'b0);
    wait_idle();

    // start_i kept high through INIT and AD rounds must not disturb the sequence
    push_msg(2, 1, 1);
    start_msg(1'b1);
    send_block(1'b0, 1, 1'b0);
    send_block(1'b1, 1, 1'b0);
    start_i = 1'b0;
    send_block(1'b1, 1, 1'b0);
    wait_idle();

    // Reset in FINAL at round 5 abandons the message
    data_valid_i = 1'b1; data_last_i = 1'b1;
    push_msg(1, 1, 0);
    start_msg(1'b0);
    send_block(1'b1, 0, 1'b1);
    send_block(1'b1, 0, 1'b1);
    repeat (4) begin
      @(posedge clk_i); #1;
    end
    check("final_rnd5", 32'(round_o), 32'd5);
    #2 resetb_i = 1'b0;
    exp_q.delete();
    n_abort++;
    #1;
    check("reset_mid_outputs", 32'(sample()), 32'(rst_v));
    data_valid_i = 1'b0; data_last_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #3 resetb_i = 1'b1;
    repeat (6) @(posedge clk_i);
    #1;
    check("idle_after_reset", 32'(busy_o), 32'd0);

    // Fresh message after reset completes normally
    data_valid_i = 1'b1; data_last_i = 1'b1;
    push_msg(1, 1, 0);
    start_msg(1'b0);
    send_block(1'b1, 0, 1'b1);
    send_block(1'b1, 0, 1'b1);
    wait_idle();
    data_valid_i = 1'b0; data_last_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("done_per_start", 32'(done_cnt), 32'(n_start - n_abort));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ascon_fsm.md
ASCON_FSM -- requirements
Module: ascon_fsm

Interface
REQ-001 No parameters; round counts fixed: pa = 12 rounds (round_o 0..11), pb = 6 rounds (round_o 6..11).
REQ-002 clk_i  in  1  single clock, all state on rising edge.
REQ-003 resetb_i  in  1  asynchronous, active-low reset.
REQ-004 start_i  in  1  start one encryption, sampled in IDLE only.
REQ-005 data_valid_i  in  1  64-bit block present on datapath data_i.
REQ-006 data_last_i  in  1  qualifies data_valid_i: last block of current phase (AD or PT).
REQ-007 data_ready_o  out  1  controller in a wait state; transfer = data_valid_i & data_ready_o.
REQ-008 select_o  out  1  0 = load external initial state, 1 = feed back state register.
REQ-009 round_o  out  4  round index to constant addition.
REQ-010 en_reg_state_o, en_xor_data_o, en_xor_begin_key_o, en_xor_lsb_o, en_xor_end_key_o, en_out_cipher_o, en_out_tag_o  out  1 each  datapath enables.
REQ-011 cipher_valid_o  out  1  one-cycle pulse, cipher register updated on previous edge.
REQ-012 busy_o  out  1  high in every state except IDLE.
REQ-013 done_o  out  1  one-cycle pulse, tag register valid.

Function
REQ-014 States: IDLE, INIT, WAIT_AD, AD_RND, WAIT_PT, PT_RND, FINAL, TAG, END; 4-bit round counter rnd, range 0..11 only, never 12..15.
REQ-015 Each permutation round = 1 cycle with en_reg_state_o = 1; en_reg_state_o = 0 in IDLE, TAG, END and in wait states without transfer.
REQ-016 IDLE: start_i = 1 -> INIT, rnd = 0; otherwise stay.
REQ-017 INIT: round_o = rnd; select_o = 0 only at rnd = 0; en_xor_end_key_o = 1 at rnd = 11; rnd increments; rnd = 11 -> WAIT_AD.
REQ-018 WAIT_AD: data_ready_o = 1; on transfer (Mealy, same cycle): round_o = 6, en_xor_data_o = 1, en_reg_state_o = 1, rnd <= 7, capture data_last_i into last_ad flag -> AD_RND.
REQ-019 AD_RND: round_o = rnd, rnd 7..11; at rnd = 11: en_xor_lsb_o = last_ad, then WAIT_PT if last_ad else WAIT_AD.
REQ-020 WAIT_PT: data_ready_o = 1; transfer with data_last_i = 0: round_o = 6, en_xor_data_o = 1, en_out_cipher_o = 1, en_reg_state_o = 1, rnd <= 7 -> PT_RND.
REQ-021 PT_RND: round_o = rnd, rnd 7..11; rnd = 11 -> WAIT_PT.
REQ-022 WAIT_PT transfer with data_last_i = 1: round_o = 0, en_xor_data_o = 1, en_xor_begin_key_o = 1, en_out_cipher_o = 1, en_reg_state_o = 1, rnd <= 1 -> FINAL.
REQ-023 FINAL: round_o = rnd, rnd 1..11; en_xor_end_key_o = 1 at rnd = 11, then TAG.
REQ-024 TAG: en_out_tag_o = 1 for exactly one cycle -> END; END: done_o = 1 for one cycle -> IDLE.
REQ-025 cipher_valid_o registered: high the cycle after any cycle with en_out_cipher_o = 1.
REQ-026 select_o = 1 in every state/cycle not named in REQ-017.
REQ-027 en_xor_lsb_o and en_xor_end_key_o never high in the same cycle; en_xor_data_o only on transfer cycles.
REQ-028 start_i ignored outside IDLE; data_valid_i/data_last_i ignored when data_ready_o = 0; data_last_i ignored when data_valid_i = 0.
REQ-029 At least one AD block and one PT block per message; padding external.

Reset
REQ-030 resetb_i = 0 immediately (no clock) forces IDLE, rnd = 0, last_ad = 0, cipher_valid_o = 0, done_o = 0; combinational outputs then: select_o = 1, round_o = 0, all enables = 0, data_ready_o = 0, busy_o = 0.
REQ-031 Reset mid-operation abandons the message; no done_o or cipher_valid_o pulse after release; next start_i begins a fresh INIT.

Verification
REQ-032 Start at cycle 0, 1 AD + 1 PT (valid held high, last = 1): INIT cycles 1-12 (select_o = 0 cycle 1, end key cycle 12), AD rounds 13-18 (lsb cycle 18), FINAL 19-30 (cipher enable + begin key cycle 19, end key cycle 30), cipher_valid_o cycle 20, en_out_tag_o cycle 31, done_o cycle 32.
REQ-033 3 AD + 2 PT blocks, valid delayed 3 cycles each wait: data_ready_o high during waits, en_xor_lsb_o exactly once, two cipher_valid_o pulses, one done_o.
REQ-034 start_i pulsed during INIT and AD_RND: ignored, round sequence unchanged.
REQ-035 data_valid_i high during INIT/AD_RND/PT_RND: no en_xor_data_o, data_ready_o = 0.
REQ-036 resetb_i low at FINAL rnd = 5: all outputs at reset values same cycle, no done_o; new start_i completes normally.
REQ-037 Assertions: round_o <= 11 always; round_o >= 6 in AD_RND/PT_RND; one done_o per accepted start_i.
